// File: rtl/led_pattern.sv
// LED pattern sequencer. Synchronises a slow tick from the clock divider and,
// on each rising edge, steps a blink/chase/binary/fill pattern on the LED bank.
// Ports: clk_in, rst_in (async, active-high), tick_in (async square wave),
//   mode_in (00 blink, 01 chase, 10 binary, 11 fill), pause_in, brightness_in,
//   leds_out (bit 0 = LED 0), step_out (one-cycle strobe per accepted step).
// Optional macro LED_PWM_EN: registered PWM brightness gating on leds_out.
module led_pattern #(
  parameter int LED_COUNT = 8,
  parameter int PWM_BITS  = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tick_in,
  input  logic [1:0]           mode_in,
  input  logic                 pause_in,
  input  logic [PWM_BITS-1:0]  brightness_in,
  output logic [LED_COUNT-1:0] leds_out,
  output logic                 step_out
);

  localparam int PW = $clog2(LED_COUNT);

  localparam logic [1:0] M_BLINK  = 2'b00;
  localparam logic [1:0] M_CHASE  = 2'b01;
  localparam logic [1:0] M_BINARY = 2'b10;
  localparam logic [1:0] M_FILL   = 2'b11;

  localparam logic [PW-1:0] POS_MAX = PW'(LED_COUNT - 1);
  localparam logic [PW-1:0] POS_MIN = '0;

  localparam logic [LED_COUNT-1:0] ONES = '1;
  localparam logic [LED_COUNT-1:0] ONE  = LED_COUNT'(1);

  logic                 r_s1, r_s2, r_s3;
  logic [1:0]           r_mode;
  logic [LED_COUNT-1:0] r_pat;
  logic [PW-1:0]        r_pos;
  logic                 r_dir_up;
  logic                 r_step;

  logic                 w_rise;
  logic                 w_step;
  logic [1:0]           w_mode_nxt;
  logic [LED_COUNT-1:0] w_pat_nxt;
  logic [PW-1:0]        w_pos_nxt;
  logic                 w_dir_nxt;

  // Chain resets high so a tick already high at release is not an edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= tick_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_step = w_rise & ~pause_in;

  always_comb begin
    w_mode_nxt = r_mode;
    w_pat_nxt  = r_pat;
    w_pos_nxt  = r_pos;
    w_dir_nxt  = r_dir_up;
    if (mode_in != r_mode) begin
      // A mode change loads the entry pattern instead of advancing.
      w_mode_nxt = mode_in;
      w_pos_nxt  = '0;
      w_dir_nxt  = 1'b1;
      unique case (mode_in)
        M_BLINK:  w_pat_nxt = ONES;
        M_CHASE:  w_pat_nxt = ONE;
        M_BINARY: w_pat_nxt = '0;
        M_FILL:   w_pat_nxt = ONE;
      endcase
    end else begin
      unique case (r_mode)
        M_BLINK:  w_pat_nxt = ~r_pat;
        M_CHASE: begin
          if (r_dir_up) begin
            if (r_pos == POS_MAX) begin
              w_pos_nxt = r_pos - 1'b1;
              w_dir_nxt = 1'b0;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end else begin
            if (r_pos == POS_MIN) begin
              w_pos_nxt = r_pos + 1'b1;
              w_dir_nxt = 1'b1;
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end
          w_pat_nxt = ONE << w_pos_nxt;
        end
        M_BINARY: w_pat_nxt = r_pat + ONE;
        M_FILL: begin
          if (r_pat == ONES) w_pat_nxt = '0;
          else               w_pat_nxt = (r_pat << 1) | ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode   <= M_BLINK;
      r_pat    <= '0;
      r_pos    <= '0;
      r_dir_up <= 1'b1;
      r_step   <= 1'b0;
    end else begin
      r_step <= w_step;
      if (w_step) begin
        r_mode   <= w_mode_nxt;
        r_pat    <= w_pat_nxt;
        r_pos    <= w_pos_nxt;
        r_dir_up <= w_dir_nxt;
      end
    end
  end

  assign step_out = r_step;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0]  r_cnt;
  logic [LED_COUNT-1:0] r_leds;
  logic                 w_on;

  // All-ones brightness means 100% duty, not 15/16.
  assign w_on = (&brightness_in) | (r_cnt < brightness_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_leds <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_leds <= w_on ? r_pat : '0;
    end
  end

  assign leds_out = r_leds;
`else
  logic w_unused;
  assign w_unused = ^brightness_in;
  assign leds_out = r_pat;
`endif

endmodule

// File: tb/tb_led_pattern.sv
// Scoreboard bench for led_pattern (LED_COUNT=4): stimulus pushes expected
// patterns, a monitor pops and compares on every step_out strobe.
module tb_led_pattern;

  localparam int N  = 4;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [1:0]    mode;
  logic          pause;
  logic [PB-1:0] bright;
  logic [N-1:0]  leds;
  logic          step;

  int n_cmp = 0;
  int n_err = 0;
  int n_steps = 0;
  logic [N-1:0] exp_q[$];

  led_pattern #(.LED_COUNT(N), .PWM_BITS(PB)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .tick_in      (tick),
    .mode_in      (mode),
    .pause_in     (pause),
    .brightness_in(bright),
    .leds_out     (leds),
    .step_out     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && step) begin
      n_steps++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_step: got step leds %0h expected none",
                 leds);
      end else begin
`ifdef LED_PWM_EN
        @(negedge clk);
`endif
        chk("step_leds", 32'(leds), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_tick(input logic [N-1:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    @(negedge clk) tick = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  int s0;
  int hi;
  int lo;

  initial begin
    rst = 1'b1;
    tick = 1'b1;
    mode = 2'b00;
    pause = 1'b0;
    bright = '1;
    repeat (3) @(negedge clk);
    chk("reset_leds", 32'(leds), 0);
    chk("reset_step", 32'(step), 0);
    rst = 1'b0;
    s0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (step) s0++;
    end
    chk("no_false_edge", s0, 0);
    chk("idle_leds", 32'(leds), 0);

    // Latency: edge k samples tick, step_out at k+2.
    tick = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(4'hF);
    tick = 1'b1;
    @(negedge clk);
    chk("lat_k", 32'(step), 0);
    @(negedge clk);
    chk("lat_k1", 32'(step), 0);
    @(negedge clk);
    chk("lat_k2", 32'(step), 1);
    @(negedge clk);
    chk("lat_one_cycle", 32'(step), 0);
    repeat (3) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);

    // CHASE bounce.
    mode = 2'b01;
    do_tick(4'b0001, 1);
    do_tick(4'b0010, 1);
    do_tick(4'b0100, 1);
    do_tick(4'b1000, 1);
    do_tick(4'b0100, 1);
    do_tick(4'b0010, 1);
    do_tick(4'b0001, 1);
    do_tick(4'b0010, 1);

    // BINARY: entry 0, count up, wrap.
    mode = 2'b10;
    for (int i = 0; i < 17; i++) do_tick(4'(i), 1);

    // FILL then pause.
    mode = 2'b11;
    do_tick(4'b0001, 1);
    do_tick(4'b0011, 1);
    do_tick(4'b0111, 1);
    do_tick(4'b1111, 1);
    do_tick(4'b0000, 1);
    do_tick(4'b0001, 1);
    pause = 1'b1;
    s0 = n_steps;
    repeat (3) do_tick('0, 0);
    chk("pause_steps", n_steps - s0, 0);
    chk("pause_leds", 32'(leds), 32'h1);
    pause = 1'b0;
    do_tick(4'b0011, 1);

    // Mode change between ticks has no effect until a step.
    mode = 2'b01;
    do_tick(4'b0001, 1);
    do_tick(4'b0010, 1);
    do_tick(4'b0100, 1);
    mode = 2'b10;
    repeat (10) @(negedge clk);
    chk("mode_hold", 32'(leds), 32'h4);
    do_tick(4'b0000, 1);
    mode = 2'b11;
    do_tick(4'b0001, 1);
    do_tick(4'b0011, 1);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'(leds), 0);
    chk("async_rst_step", 32'(step), 0);
    @(negedge clk);
    rst = 1'b0;
    mode = 2'b00;
    repeat (4) @(negedge clk);

`ifdef LED_PWM_EN
    do_tick(4'hF, 1);
    bright = 4'd4;
    repeat (3) @(negedge clk);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (leds == 4'hF) hi++;
      if (leds == 4'h0) lo++;
    end
    chk("pwm4_hi", hi, 4);
    chk("pwm4_lo", lo, 12);
    bright = 4'd15;
    repeat (3) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (leds == 4'hF) hi++;
    end
    chk("pwm15_hi", hi, 16);
    bright = 4'd0;
    repeat (3) @(negedge clk);
    lo = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (leds == 4'h0) lo++;
    end
    chk("pwm0_lo", lo, 16);
`else
    do_tick(4'hF, 1);
    do_tick(4'h0, 1);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern.md
Name: led_pattern

Overview:
- Downstream consumer of the clock divider: takes its slow divided square wave as a data input in the fast system clock domain.
- Synchronises that input, detects its rising edges, and on each one advances an LED pattern state machine (blink, chase, binary count, fill).
- Drives the board LED bank directly. The optional PWM stage sets brightness.

Parameters:
- LED_COUNT, 8, number of LEDs driven; legal range 2..32.
- PWM_BITS, 4, width of brightness input and PWM counter; used only with LED_PWM_EN.

Ports:
- clk_in  input  1  system clock (fast, undivided).
- rst_in  input  1  asynchronous reset, active-high.
- tick_in  input  1  divided square wave from the clock divider; asynchronous to clk_in for synchronisation purposes.
- mode_in  input  2  pattern select: 00 BLINK, 01 CHASE, 10 BINARY, 11 FILL.
- pause_in  input  1  high = freeze pattern, ignore ticks.
- brightness_in  input  PWM_BITS  PWM duty; ignored without LED_PWM_EN.
- leds_out  output  LED_COUNT  LED drive, bit 0 = LED 0.
- step_out  output  1  one-cycle strobe on every accepted step.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - Sync flops s1, s2, s3 = 1 (no false edge if tick_in is high at release).
  - Mode state = BLINK; leds pattern = 0; step_out = 0.
  - Chase pos = 0, direction = up; PWM counter = 0.
- Synchroniser: tick_in -> s1 -> s2 -> s3 on clk_in; rise = s2 & ~s3 (combinational).
- Step: step = rise & ~pause_in. On the clk_in edge where step is true:
  - Pattern updates.
  - step_out registers 1 for exactly one cycle.
- Latency: tick_in high before clk_in edge k -> leds_out and step_out change at edge k+2.
- Pause: while pause_in is high, steps are dropped (no step_out, pattern and mode held). The sync chain keeps running, so no stale edge fires on release.
- Mode is sampled only on a step.
  - If mode_in differs from the current mode: switch mode and load the entry pattern instead of advancing.
  - Entry patterns: BLINK = all ones; CHASE = one-hot bit 0, pos 0, dir up; BINARY = 0; FILL = ...0001.
  - Mode changes between steps have no effect until the next step.
- BLINK: pattern <= ~pattern.
- CHASE: one-hot bounce, pattern = 1 << pos.
  - Up: pos+1, except at pos LED_COUNT-1 -> pos LED_COUNT-2, dir down.
  - Down: pos-1, except at pos 0 -> pos 1, dir up.
  - LED_COUNT=2 gives 01,10,01,...
- BINARY: pattern <= pattern + 1, modulo 2^LED_COUNT (all ones -> 0).
- FILL: pattern <= (pattern << 1) | 1; when pattern is all ones, next = 0, then ...0001 on the following step.
- Without the optional feature, leds_out = pattern register (registered output, no combinational path from inputs).

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Free-running PWM_BITS counter, increments every clk_in, wraps to 0.
  - leds_out = pattern AND (cnt < brightness_in); brightness_in all ones forces full on (duty 100%); 0 = off.
  - Gating output is registered: one extra cycle of latency on leds_out only. step_out timing unchanged.
- Undefined: no counter; brightness_in ignored; leds_out = pattern.

Test Plan:
- Reset/sync: hold rst_in with tick_in=1, release, keep tick_in=1 for 20 cycles -> leds_out=0x00 and step_out never asserts. Drop then raise tick_in at edge k -> step_out=1 only in the cycle after edge k+2, leds_out=0xFF (BLINK toggle).
- CHASE, LED_COUNT=4, mode_in=01, 8 ticks -> first tick loads 0001, then 0010,0100,1000,0100,0010,0001,0010.
- BINARY, LED_COUNT=4, preload by 16 ticks after entry -> leds_out 0x0 then 1..F, and the 17th tick wraps F->0.
- FILL + pause, LED_COUNT=4: entry 0001, then 0011,0111,1111,0000,0001. Assert pause_in across 3 ticks -> leds_out and step_out frozen; release -> next tick advances exactly one step.
- Mode switch mid-run: CHASE at 0100, change mode_in to 10 between ticks -> leds_out unchanged until next tick, then 0x0. Assert rst_in mid-cycle -> leds_out=0 immediately, without waiting for a clk_in edge.
- LED_PWM_EN, PWM_BITS=4, BLINK all ones:
  - brightness_in=4 -> each LED high exactly 4 of every 16 cycles.
  - brightness_in=15 -> constantly high.
  - brightness_in=0 -> constantly low.
